// File: rtl/debug_halt_ctrl_if.sv
// Signal bundle between debug_halt_ctrl and its surroundings: UART line, sampled
// core clock and CPU bus in; halt/breakpoint status and FSM debug state out.
interface debug_halt_ctrl_if;
  logic        rx;
  logic        gb_clk;
  logic [15:0] addr;
  logic        rd;
  logic        halt;
  logic        bp_armed;
  logic [15:0] bp_addr;
  logic        bp_hit;
  logic        cmd_err;
  // {rx_state[1:0], parser_state, ctrl_state[1:0]}
  logic [4:0]  dbg_state;

  modport slave (
    input  rx, gb_clk, addr, rd,
    output halt, bp_armed, bp_addr, bp_hit, cmd_err, dbg_state
  );

  modport master (
    output rx, gb_clk, addr, rd,
    input  halt, bp_armed, bp_addr, bp_hit, cmd_err, dbg_state
  );
endinterface

// File: rtl/debug_halt_ctrl.sv
// Debug halt controller: UART command receiver, command parser and the
// RUN/HALTED/STEP_WAIT control FSM that drives halt, plus one read breakpoint.
module debug_halt_ctrl #(
  parameter int CLKS_PER_BIT = 868,
  parameter int SYNC_STAGES  = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  debug_halt_ctrl_if.slave  bus
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  localparam logic [7:0] CH_H = 8'h48;
  localparam logic [7:0] CH_C = 8'h43;
  localparam logic [7:0] CH_S = 8'h53;
  localparam logic [7:0] CH_X = 8'h58;
  localparam logic [7:0] CH_B = 8'h42;

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
  typedef enum logic       {P_IDLE, P_BP}                     p_state_t;
  typedef enum logic [1:0] {RUN, HALTED, STEP_WAIT}           ctrl_state_t;

  // ---------------------------------------------------------------------------
  // Input synchronizers and gb_clk rising-edge detect
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] r_rx_sync;
  logic [SYNC_STAGES-1:0] r_gb_sync;
  logic                   r_gb_prev;
  logic                   w_rx;
  logic                   w_gb_rise;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_rx_sync <= '1;
      r_gb_sync <= '0;
      r_gb_prev <= 1'b0;
    end else begin
      r_rx_sync <= {r_rx_sync[SYNC_STAGES-2:0], bus.rx};
      r_gb_sync <= {r_gb_sync[SYNC_STAGES-2:0], bus.gb_clk};
      r_gb_prev <= r_gb_sync[SYNC_STAGES-1];
    end
  end

  assign w_rx      = r_rx_sync[SYNC_STAGES-1];
  assign w_gb_rise = r_gb_sync[SYNC_STAGES-1] & ~r_gb_prev;

  // ---------------------------------------------------------------------------
  // UART receiver (8N1, LSB first, mid-bit sampling)
  // w_rx_valid is a one-cycle strobe with the byte in r_shift; there is no
  // ready/back-pressure, every consumer must act in that same cycle.
  // ---------------------------------------------------------------------------
  rx_state_t       r_rx_state, w_rx_state_nxt;
  logic [CW-1:0]   r_cnt,      w_cnt_nxt;
  logic [2:0]      r_bit,      w_bit_nxt;
  logic [7:0]      r_shift,    w_shift_nxt;
  logic            w_rx_valid;
  logic            w_frame_err;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_rx_state <= R_IDLE;
      r_cnt      <= '0;
      r_bit      <= '0;
      r_shift    <= '0;
    end else begin
      r_rx_state <= w_rx_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_bit      <= w_bit_nxt;
      r_shift    <= w_shift_nxt;
    end
  end

  always_comb begin
    w_rx_state_nxt = r_rx_state;
    w_cnt_nxt      = r_cnt;
    w_bit_nxt      = r_bit;
    w_shift_nxt    = r_shift;
    w_rx_valid     = 1'b0;
    w_frame_err    = 1'b0;
    case (r_rx_state)
      R_IDLE: begin
        if (!w_rx) begin
          w_rx_state_nxt = R_START;
          w_cnt_nxt      = '0;
        end
      end
      R_START: begin
        if (r_cnt == HALF_M1) begin
          // A start bit that has gone high again by mid-bit is a glitch.
          w_cnt_nxt      = '0;
          w_bit_nxt      = '0;
          w_rx_state_nxt = w_rx ? R_IDLE : R_DATA;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      R_DATA: begin
        if (r_cnt == FULL_M1) begin
          w_cnt_nxt   = '0;
          w_shift_nxt = {w_rx, r_shift[7:1]};
          w_bit_nxt   = r_bit + 3'd1;
          if (r_bit == 3'd7) w_rx_state_nxt = R_STOP;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      R_STOP: begin
        if (r_cnt == FULL_M1) begin
          w_cnt_nxt      = '0;
          w_rx_state_nxt = R_IDLE;
          if (w_rx) w_rx_valid  = 1'b1;
          else      w_frame_err = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      default: w_rx_state_nxt = R_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Command parser
  // ---------------------------------------------------------------------------
  function automatic logic [4:0] hex_decode(input logic [7:0] c);
    // Returns {valid, nibble}.
    if (c >= 8'h30 && c <= 8'h39)      return {1'b1, c[3:0]};
    else if (c >= 8'h41 && c <= 8'h46) return {1'b1, 4'(c[3:0] + 4'd9)};
    else if (c >= 8'h61 && c <= 8'h66) return {1'b1, 4'(c[3:0] + 4'd9)};
    else                               return 5'b0;
  endfunction

  p_state_t    r_p_state,  w_p_state_nxt;
  logic [1:0]  r_nib_cnt,  w_nib_cnt_nxt;
  logic [15:0] r_shadow,   w_shadow_nxt;
  logic [15:0] r_bp_addr,  w_bp_addr_nxt;
  logic        r_bp_armed, w_bp_armed_nxt;
  logic [4:0]  w_hex;
  logic        w_bp_write;
  logic        w_hex_err;
  logic        w_cmd_h;
  logic        w_cmd_c;
  logic        w_cmd_s;

  assign w_hex = hex_decode(r_shift);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_p_state  <= P_IDLE;
      r_nib_cnt  <= '0;
      r_shadow   <= '0;
      r_bp_addr  <= '0;
      r_bp_armed <= 1'b0;
    end else begin
      r_p_state  <= w_p_state_nxt;
      r_nib_cnt  <= w_nib_cnt_nxt;
      r_shadow   <= w_shadow_nxt;
      r_bp_addr  <= w_bp_addr_nxt;
      r_bp_armed <= w_bp_armed_nxt;
    end
  end

  always_comb begin
    w_p_state_nxt  = r_p_state;
    w_nib_cnt_nxt  = r_nib_cnt;
    w_shadow_nxt   = r_shadow;
    w_bp_addr_nxt  = r_bp_addr;
    w_bp_armed_nxt = r_bp_armed;
    w_bp_write     = 1'b0;
    w_hex_err      = 1'b0;
    w_cmd_h        = 1'b0;
    w_cmd_c        = 1'b0;
    w_cmd_s        = 1'b0;
    if (w_rx_valid) begin
      case (r_p_state)
        P_IDLE: begin
          case (r_shift)
            CH_H: w_cmd_h = 1'b1;
            CH_C: w_cmd_c = 1'b1;
            CH_S: w_cmd_s = 1'b1;
            CH_X: w_bp_armed_nxt = 1'b0;
            CH_B: begin
              w_p_state_nxt = P_BP;
              w_nib_cnt_nxt = '0;
            end
            default: ;
          endcase
        end
        P_BP: begin
          if (w_hex[4]) begin
            w_shadow_nxt  = {r_shadow[11:0], w_hex[3:0]};
            w_nib_cnt_nxt = r_nib_cnt + 2'd1;
            if (r_nib_cnt == 2'd3) begin
              w_bp_addr_nxt  = {r_shadow[11:0], w_hex[3:0]};
              w_bp_armed_nxt = 1'b1;
              w_bp_write     = 1'b1;
              w_p_state_nxt  = P_IDLE;
            end
          end else begin
            // Bad digit abandons the address; the old breakpoint stays live.
            w_hex_err     = 1'b1;
            w_p_state_nxt = P_IDLE;
          end
        end
        default: w_p_state_nxt = P_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  ctrl_state_t r_ctrl, w_ctrl_nxt;
  logic        r_skip, w_skip_nxt;
  logic        r_halt;
  logic        r_bp_hit;
  logic        r_cmd_err;
  logic        w_bp_match;
  logic        w_bp_hit_nxt;

  // skip masks the breakpoint the core is parked on until the bus moves away.
  assign w_bp_match = r_bp_armed && !bus.rd && (bus.addr == r_bp_addr) && !r_skip;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_ctrl    <= RUN;
      r_skip    <= 1'b0;
      r_halt    <= 1'b0;
      r_bp_hit  <= 1'b0;
      r_cmd_err <= 1'b0;
    end else begin
      r_ctrl    <= w_ctrl_nxt;
      r_skip    <= w_skip_nxt;
      r_halt    <= (w_ctrl_nxt == HALTED);
      r_bp_hit  <= w_bp_hit_nxt;
      r_cmd_err <= w_frame_err | w_hex_err;
    end
  end

  always_comb begin
    w_ctrl_nxt   = r_ctrl;
    w_bp_hit_nxt = 1'b0;
    w_skip_nxt   = (bus.addr != r_bp_addr) ? 1'b0 : r_skip;
    case (r_ctrl)
      RUN: begin
        // Any command arriving in the same cycle takes priority over a match.
        if (w_cmd_h) begin
          w_ctrl_nxt = HALTED;
        end else if (w_bp_match && !w_cmd_c && !w_cmd_s) begin
          w_ctrl_nxt   = HALTED;
          w_bp_hit_nxt = 1'b1;
        end
      end
      HALTED: begin
        if (w_cmd_c) begin
          w_ctrl_nxt = RUN;
          w_skip_nxt = 1'b1;
        end else if (w_cmd_s) begin
          w_ctrl_nxt = STEP_WAIT;
          w_skip_nxt = 1'b1;
        end
      end
      STEP_WAIT: begin
        if (w_cmd_h)        w_ctrl_nxt = HALTED;
        else if (w_cmd_c)   w_ctrl_nxt = RUN;
        else if (w_gb_rise) w_ctrl_nxt = HALTED;
      end
      default: w_ctrl_nxt = RUN;
    endcase
    if (w_bp_write) w_skip_nxt = 1'b0;
  end

  assign bus.halt      = r_halt;
  assign bus.bp_armed  = r_bp_armed;
  assign bus.bp_addr   = r_bp_addr;
  assign bus.bp_hit    = r_bp_hit;
  assign bus.cmd_err   = r_cmd_err;
  assign bus.dbg_state = {r_rx_state, r_p_state, r_ctrl};

endmodule
